// File: rtl/instr_assembler_if.sv
// Field-input handshake and instruction-memory write port of instr_assembler.
// master: loader side driving fields; slave: the assembler.
interface instr_assembler_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              Start;
    logic              InValid;
    logic              InReady;
    logic [2:0]        InKind;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [4:0]        Shamt;
    logic [5:0]        Funct;
    logic [15:0]       Imm;
    logic [25:0]       Target;
    logic              ImWrEn;
    logic [ADDR_W-1:0] ImAddr;
    logic [31:0]       ImWrData;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Error;

    modport master (
        output Start, InValid, InKind, Rs, Rt, Rd, Shamt, Funct, Imm, Target,
        input  InReady, ImWrEn, ImAddr, ImWrData, Count, Full, Error
    );

    modport slave (
        input  Start, InValid, InKind, Rs, Rt, Rd, Shamt, Funct, Imm, Target,
        output InReady, ImWrEn, ImAddr, ImWrData, Count, Full, Error
    );
endinterface

// File: rtl/instr_assembler.sv
// Encodes decoded MIPS instruction fields and writes them to consecutive
// instruction-memory words. Define ASM_JAL_EN to make InKind 110 (jal) legal.
module instr_assembler #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               CLK,
    input  logic               RST,
    instr_assembler_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       data_q, data_d;
    logic              error_q, error_d;

    logic [31:0]       enc_word;
    logic              enc_legal;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (bus.InKind)
            3'b000: enc_word = {6'b100011, bus.Rs, bus.Rt, bus.Imm};
            3'b001: enc_word = {6'b101011, bus.Rs, bus.Rt, bus.Imm};
            3'b010: enc_word = {6'b000000, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, bus.Funct};
            3'b011: enc_word = {6'b001000, bus.Rs, bus.Rt, bus.Imm};
            3'b100: enc_word = {6'b000100, bus.Rs, bus.Rt, bus.Imm};
            3'b101: enc_word = {6'b000010, bus.Target};
`ifdef ASM_JAL_EN
            3'b110: enc_word = {6'b000011, bus.Target};
`else
            3'b110: enc_legal = 1'b0;
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    // Start overrides everything; a write already on the bus still completes
    // because ImWrEn follows the current state, only the counters are cleared.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        error_d = error_q;
        if (bus.Start) begin
            state_d = IDLE;
            addr_d  = BASE;
            count_d = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.InValid) begin
                        if (enc_legal) begin
                            data_d  = enc_word;
                            state_d = WRITE;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    state_d = (count_d == FULL_CNT) ? FULL : IDLE;
                end
                FULL: state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    assign bus.InReady  = (state_q == IDLE);
    assign bus.ImWrEn   = (state_q == WRITE);
    assign bus.ImAddr   = addr_q;
    assign bus.ImWrData = data_q;
    assign bus.Count    = count_q;
    assign bus.Full     = (count_q == FULL_CNT);
    assign bus.Error    = error_q;
endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler with a 4-word memory (ADDR_W=2).
module tb_instr_assembler;
    localparam int unsigned AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_assembler_if #(.ADDR_W(AW)) bus ();

    instr_assembler #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe seen must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.ImWrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.ImAddr), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", 32'(bus.ImAddr), 32'(w.addr));
                chk("write_data", bus.ImWrData, w.data);
            end
        end
    end

    task automatic fields(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] funct,
                          input logic [15:0] imm, input logic [25:0] tgt);
        bus.InKind = kind; bus.Rs = rs; bus.Rt = rt; bus.Rd = rd;
        bus.Shamt = 5'd0; bus.Funct = funct; bus.Imm = imm; bus.Target = tgt;
    endtask

    // One transfer from IDLE; fields must already be set.
    task automatic xfer(input bit legal, input logic [AW-1:0] addr, input logic [31:0] data);
        wr_t w;
        @(negedge clk);
        chk("in_ready_before_xfer", 32'(bus.InReady), 32'd1);
        bus.InValid = 1'b1;
        if (legal) begin
            w.addr = addr; w.data = data;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1 bus.InValid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.InValid = 1'b0;
        fields(3'b000, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        #12;
        // Reset state
        chk("rst_in_ready", 32'(bus.InReady), 32'd1);
        chk("rst_wr_en", 32'(bus.ImWrEn), 32'd0);
        chk("rst_addr", 32'(bus.ImAddr), 32'd0);
        chk("rst_data", bus.ImWrData, 32'd0);
        chk("rst_count", 32'(bus.Count), 32'd0);
        chk("rst_full", 32'(bus.Full), 32'd0);
        chk("rst_error", 32'(bus.Error), 32'd0);
        rst_n = 1'b1;

        // lw Rs=1 Rt=2 Imm=4
        fields(3'b000, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0);
        xfer(1'b1, 2'd0, 32'h8C22_0004);
        @(negedge clk);
        chk("lw_in_ready_low", 32'(bus.InReady), 32'd0);
        @(negedge clk);
        chk("lw_count", 32'(bus.Count), 32'd1);
        chk("lw_addr_next", 32'(bus.ImAddr), 32'd1);

        // Back-to-back with InValid held: R-type then beq
        start_pulse();
        @(negedge clk);
        fields(3'b010, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0);
        bus.InValid = 1'b1;
        exp_q.push_back('{addr: 2'd0, data: 32'h0022_1820});
        chk("b2b_ready0", 32'(bus.InReady), 32'd1);
        @(negedge clk);
        chk("b2b_ready1", 32'(bus.InReady), 32'd0);
        fields(3'b100, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        exp_q.push_back('{addr: 2'd1, data: 32'h1022_FFFF});
        @(negedge clk);
        chk("b2b_ready2", 32'(bus.InReady), 32'd1);
        @(negedge clk);
        chk("b2b_ready3", 32'(bus.InReady), 32'd0);
        bus.InValid = 1'b0;
        @(negedge clk);
        chk("b2b_count", 32'(bus.Count), 32'd2);

        // Fill all four words with addi Rs=0 Rt=1 Imm=5
        start_pulse();
        fields(3'b011, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0005, 26'd0);
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, AW'(i), 32'h2001_0005);
            if (i < 3) @(negedge clk);
        end
        wait_neg(2);
        chk("full_flag", 32'(bus.Full), 32'd1);
        chk("full_count", 32'(bus.Count), 32'd4);
        chk("full_in_ready", 32'(bus.InReady), 32'd0);
        chk("full_addr_wrap", 32'(bus.ImAddr), 32'd0);
        bus.InValid = 1'b1;
        wait_neg(3);
        bus.InValid = 1'b0;
        chk("full_count_sat", 32'(bus.Count), 32'd4);
        start_pulse();
        @(negedge clk);
        chk("restart_full", 32'(bus.Full), 32'd0);
        chk("restart_addr", 32'(bus.ImAddr), 32'd0);
        chk("restart_count", 32'(bus.Count), 32'd0);

        // Illegal kind sets sticky Error, no write
        fields(3'b111, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        xfer(1'b0, 2'd0, 32'd0);
        @(negedge clk);
        chk("illegal_error", 32'(bus.Error), 32'd1);
        chk("illegal_ready", 32'(bus.InReady), 32'd1);
        chk("illegal_count", 32'(bus.Count), 32'd0);
        fields(3'b001, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0);
        xfer(1'b1, 2'd0, 32'hAC64_0010);
        wait_neg(2);
        chk("error_sticky", 32'(bus.Error), 32'd1);
        chk("sw_count", 32'(bus.Count), 32'd1);
        start_pulse();
        @(negedge clk);
        chk("start_clears_error", 32'(bus.Error), 32'd0);

        // jal Target=0x10
        fields(3'b110, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010);
`ifdef ASM_JAL_EN
        xfer(1'b1, 2'd0, 32'h0C00_0010);
        wait_neg(2);
        chk("jal_error", 32'(bus.Error), 32'd0);
        chk("jal_count", 32'(bus.Count), 32'd1);
`else
        xfer(1'b0, 2'd0, 32'd0);
        wait_neg(2);
        chk("jal_error", 32'(bus.Error), 32'd1);
        chk("jal_count", 32'(bus.Count), 32'd0);
`endif
        start_pulse();

        // Start in WRITE with InValid high: write completes, counters cleared
        fields(3'b101, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0010);
        xfer(1'b1, 2'd0, 32'h0800_0010);
        @(negedge clk);
        fields(3'b011, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0005, 26'd0);
        bus.Start = 1'b1;
        bus.InValid = 1'b1;
        @(negedge clk);
        chk("startw_state_idle", 32'(bus.InReady), 32'd1);
        chk("startw_count", 32'(bus.Count), 32'd0);
        chk("startw_addr", 32'(bus.ImAddr), 32'd0);
        @(negedge clk);
        chk("startw_no_xfer", 32'(bus.InReady), 32'd1);
        chk("startw_no_xfer_count", 32'(bus.Count), 32'd0);
        bus.Start = 1'b0;
        bus.InValid = 1'b0;

        // RST mid-WRITE after one completed write
        xfer(1'b1, 2'd0, 32'h2001_0005);
        @(negedge clk);
        @(negedge clk);
        xfer(1'b1, 2'd1, 32'h2001_0005);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wr_en", 32'(bus.ImWrEn), 32'd0);
        chk("rstw_in_ready", 32'(bus.InReady), 32'd1);
        chk("rstw_addr", 32'(bus.ImAddr), 32'd0);
        chk("rstw_data", bus.ImWrData, 32'd0);
        chk("rstw_count", 32'(bus.Count), 32'd0);
        chk("rstw_error", 32'(bus.Error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(2);

        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
